// File: rtl/df_ctrl_pkg.sv
// Shared dataflow-controller types: tile loop-nest config, tile descriptor, iterator FSM states.
package df_ctrl_pkg;
  localparam int TP_IDX_W = 16;
  localparam int TP_OFF_W = 32;

  typedef struct packed {
    logic [TP_OFF_W-1:0] x_step;
    logic [TP_OFF_W-1:0] y_step;
    logic [TP_OFF_W-1:0] k_step;
  } PsumsTilePointer;

  typedef struct packed {
    logic [TP_OFF_W-1:0] x_step;
    logic [TP_OFF_W-1:0] y_step;
    logic [TP_OFF_W-1:0] c_step;
  } IfmapsTilePointer;

  typedef struct packed {
    logic [TP_OFF_W-1:0] k_step;
    logic [TP_OFF_W-1:0] c_step;
  } WeightsTilePointer;

  typedef struct packed {
    logic [TP_IDX_W-1:0] x_lim;
    logic [TP_IDX_W-1:0] y_lim;
    logic [TP_IDX_W-1:0] k_lim;
    logic [TP_IDX_W-1:0] c_lim;
    PsumsTilePointer     psums;
    IfmapsTilePointer    ifmaps;
    WeightsTilePointer   weights;
  } TilePointers;

  typedef struct packed {
    logic [TP_OFF_W-1:0] psums_off;
    logic [TP_OFF_W-1:0] ifmaps_off;
    logic [TP_OFF_W-1:0] weights_off;
    logic                first_c;
    logic                last_c;
    logic                last_tile;
  } TileDesc;

  typedef enum logic [1:0] {IDLE, RUN, DONE} iter_state_e;
endpackage

// File: rtl/df_loop_counter.sv
// One loop level: index counter that steps on i_inc and wraps to 0 past i_lim.
module df_loop_counter #(
  parameter int IDX_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [IDX_W-1:0] i_lim,
  output logic [IDX_W-1:0] o_nxt,
  output logic             o_wrap
);
  logic [IDX_W-1:0] r_idx;
  logic             w_at_lim;

  assign w_at_lim = (r_idx == i_lim);
  assign o_wrap   = i_inc & w_at_lim;

  // o_nxt is the index the level will hold after this edge; the parent uses it for flags
  always_comb begin
    o_nxt = r_idx;
    if (i_clr)      o_nxt = '0;
    else if (i_inc) o_nxt = w_at_lim ? '0 : r_idx + IDX_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_idx <= '0;
    else         r_idx <= o_nxt;
  end
endmodule

// File: rtl/df_tile_iterator.sv
// Walks the c/x/y/k tile nest (c innermost) and emits one registered descriptor per tile over valid/ready.
module df_tile_iterator
  import df_ctrl_pkg::*;
#(
  parameter int IDX_W = TP_IDX_W,
  parameter int OFF_W = TP_OFF_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  TilePointers      i_cfg,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_tile_valid,
  input  logic             i_tile_ready,
  output logic [OFF_W-1:0] o_psums_off,
  output logic [OFF_W-1:0] o_ifmaps_off,
  output logic [OFF_W-1:0] o_weights_off,
  output logic             o_first_c,
  output logic             o_last_c,
  output logic             o_last_tile
);
  iter_state_e      r_state;
  TilePointers      r_cfg;
  TileDesc          r_desc;
  logic             r_busy, r_done, r_valid;
  // Outer-level bases; r_desc.psums_off doubles as the x-level psums accumulator
  logic [OFF_W-1:0] r_ps_y, r_ps_k, r_if_x, r_if_y, r_wt_k;

  logic             w_start, w_adv;
  logic             w_c_wrap, w_x_wrap, w_y_wrap, w_k_wrap;
  logic [IDX_W-1:0] w_c_nxt, w_x_nxt, w_y_nxt, w_k_nxt;
  logic [OFF_W-1:0] w_ps_x_inc, w_if_x_inc, w_ps_y_inc, w_if_y_inc, w_ps_k_inc, w_wt_k_inc;
  logic             w_last_c_n, w_last_n;

  assign w_start = (r_state == IDLE) & i_start;
  assign w_adv   = (r_state == RUN) & r_valid & i_tile_ready;

  df_loop_counter #(.IDX_W(IDX_W)) u_cnt_c (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_start), .i_inc(w_adv),
    .i_lim(r_cfg.c_lim), .o_nxt(w_c_nxt), .o_wrap(w_c_wrap));
  df_loop_counter #(.IDX_W(IDX_W)) u_cnt_x (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_start), .i_inc(w_c_wrap),
    .i_lim(r_cfg.x_lim), .o_nxt(w_x_nxt), .o_wrap(w_x_wrap));
  df_loop_counter #(.IDX_W(IDX_W)) u_cnt_y (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_start), .i_inc(w_x_wrap),
    .i_lim(r_cfg.y_lim), .o_nxt(w_y_nxt), .o_wrap(w_y_wrap));
  df_loop_counter #(.IDX_W(IDX_W)) u_cnt_k (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_start), .i_inc(w_y_wrap),
    .i_lim(r_cfg.k_lim), .o_nxt(w_k_nxt), .o_wrap(w_k_wrap));

  assign w_ps_x_inc = r_desc.psums_off + r_cfg.psums.x_step;
  assign w_if_x_inc = r_if_x + r_cfg.ifmaps.x_step;
  assign w_ps_y_inc = r_ps_y + r_cfg.psums.y_step;
  assign w_if_y_inc = r_if_y + r_cfg.ifmaps.y_step;
  assign w_ps_k_inc = r_ps_k + r_cfg.psums.k_step;
  assign w_wt_k_inc = r_wt_k + r_cfg.weights.k_step;

  assign w_last_c_n = (w_c_nxt == r_cfg.c_lim);
  assign w_last_n   = w_last_c_n & (w_x_nxt == r_cfg.x_lim) &
                      (w_y_nxt == r_cfg.y_lim) & (w_k_nxt == r_cfg.k_lim);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_cfg   <= '0;
      r_desc  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_ps_y  <= '0;
      r_ps_k  <= '0;
      r_if_x  <= '0;
      r_if_y  <= '0;
      r_wt_k  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= RUN;
            r_cfg   <= i_cfg;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_ps_y  <= '0;
            r_ps_k  <= '0;
            r_if_x  <= '0;
            r_if_y  <= '0;
            r_wt_k  <= '0;
            r_desc.psums_off   <= '0;
            r_desc.ifmaps_off  <= '0;
            r_desc.weights_off <= '0;
            r_desc.first_c     <= 1'b1;
            r_desc.last_c      <= (i_cfg.c_lim == '0);
            r_desc.last_tile   <= (i_cfg.c_lim == '0) & (i_cfg.x_lim == '0) &
                                  (i_cfg.y_lim == '0) & (i_cfg.k_lim == '0);
          end
        end
        RUN: begin
          if (w_adv) begin
            if (r_desc.last_tile) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_desc.first_c   <= (w_c_nxt == '0);
              r_desc.last_c    <= w_last_c_n;
              r_desc.last_tile <= w_last_n;
              if (!w_c_wrap) begin
                r_desc.ifmaps_off  <= r_desc.ifmaps_off + r_cfg.ifmaps.c_step;
                r_desc.weights_off <= r_desc.weights_off + r_cfg.weights.c_step;
              end else if (!w_x_wrap) begin
                r_desc.psums_off   <= w_ps_x_inc;
                r_if_x             <= w_if_x_inc;
                r_desc.ifmaps_off  <= w_if_x_inc;
                r_desc.weights_off <= r_wt_k;
              end else if (!w_y_wrap) begin
                r_ps_y             <= w_ps_y_inc;
                r_desc.psums_off   <= w_ps_y_inc;
                r_if_y             <= w_if_y_inc;
                r_if_x             <= w_if_y_inc;
                r_desc.ifmaps_off  <= w_if_y_inc;
                r_desc.weights_off <= r_wt_k;
              end else begin
                // k step: ifmaps has no k term, so it restarts from zero
                r_ps_k             <= w_ps_k_inc;
                r_ps_y             <= w_ps_k_inc;
                r_desc.psums_off   <= w_ps_k_inc;
                r_if_y             <= '0;
                r_if_x             <= '0;
                r_desc.ifmaps_off  <= '0;
                r_wt_k             <= w_wt_k_inc;
                r_desc.weights_off <= w_wt_k_inc;
              end
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // k wraps only on the final handshake, when the FSM leaves RUN anyway
  logic w_unused;
  assign w_unused = w_k_wrap;

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_tile_valid  = r_valid;
  assign o_psums_off   = r_desc.psums_off;
  assign o_ifmaps_off  = r_desc.ifmaps_off;
  assign o_weights_off = r_desc.weights_off;
  assign o_first_c     = r_desc.first_c;
  assign o_last_c      = r_desc.last_c;
  assign o_last_tile   = r_desc.last_tile;
endmodule

// File: tb/tb_df_tile_iterator.sv
// Directed bench for df_tile_iterator: reference nest model feeds a scoreboard checked on every handshake.
module tb_df_tile_iterator;
  import df_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        i_rstn, i_start, i_tile_ready;
  TilePointers i_cfg;
  logic        o_busy, o_done, o_tile_valid;
  logic [31:0] o_psums_off, o_ifmaps_off, o_weights_off;
  logic        o_first_c, o_last_c, o_last_tile;

  int      checks = 0;
  int      errors = 0;
  int      n_hs   = 0;
  bit      rand_ready = 0;
  bit      stall_prev = 0;
  TileDesc exp_q[$];
  TileDesc act, snap, e_desc;

  always #5 clk = ~clk;

  df_tile_iterator dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_start(i_start), .i_cfg(i_cfg),
    .o_busy(o_busy), .o_done(o_done), .o_tile_valid(o_tile_valid), .i_tile_ready(i_tile_ready),
    .o_psums_off(o_psums_off), .o_ifmaps_off(o_ifmaps_off), .o_weights_off(o_weights_off),
    .o_first_c(o_first_c), .o_last_c(o_last_c), .o_last_tile(o_last_tile));

  always_comb begin
    act.psums_off   = o_psums_off;
    act.ifmaps_off  = o_ifmaps_off;
    act.weights_off = o_weights_off;
    act.first_c     = o_first_c;
    act.last_c      = o_last_c;
    act.last_tile   = o_last_tile;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: direct multiply form of each offset, modulo 2^32
  task automatic push_nest(input TilePointers cfg);
    TileDesc d;
    for (int k = 0; k <= int'(cfg.k_lim); k++)
      for (int y = 0; y <= int'(cfg.y_lim); y++)
        for (int x = 0; x <= int'(cfg.x_lim); x++)
          for (int c = 0; c <= int'(cfg.c_lim); c++) begin
            d.psums_off   = 32'(x) * cfg.psums.x_step + 32'(y) * cfg.psums.y_step + 32'(k) * cfg.psums.k_step;
            d.ifmaps_off  = 32'(x) * cfg.ifmaps.x_step + 32'(y) * cfg.ifmaps.y_step + 32'(c) * cfg.ifmaps.c_step;
            d.weights_off = 32'(k) * cfg.weights.k_step + 32'(c) * cfg.weights.c_step;
            d.first_c     = (c == 0);
            d.last_c      = (c == int'(cfg.c_lim));
            d.last_tile   = (c == int'(cfg.c_lim)) && (x == int'(cfg.x_lim)) &&
                            (y == int'(cfg.y_lim)) && (k == int'(cfg.k_lim));
            exp_q.push_back(d);
          end
  endtask

  // Scoreboard and stall-stability monitor
  always @(negedge clk) begin
    if (stall_prev) begin
      check("stall_valid_held", o_tile_valid, 1'b1);
      check("stall_desc_held", act, snap);
    end
    if (o_tile_valid && i_tile_ready) begin
      n_hs++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_tile: observed %0h expected none", act);
      end
      if (exp_q.size() != 0) begin
        e_desc = exp_q.pop_front();
        check("tile_desc", act, e_desc);
      end
    end
    stall_prev = o_tile_valid && !i_tile_ready;
    snap       = act;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) i_tile_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_start(input TilePointers cfg);
    @(posedge clk); #1;
    i_cfg   = cfg;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // mode 1 pulses start with a garbage cfg mid-run
  task automatic run_test(input string tag, input TilePointers cfg, input int mode);
    int n;
    int tiles;
    bit seen;
    tiles = (int'(cfg.k_lim) + 1) * (int'(cfg.y_lim) + 1) * (int'(cfg.x_lim) + 1) * (int'(cfg.c_lim) + 1);
    push_nest(cfg);
    do_start(cfg);
    seen = 0;
    for (n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 1) check({tag, "_busy"}, o_busy, 1'b1);
      if (mode == 1 && n == 3) begin
        i_cfg   = '1;
        i_start = 1'b1;
      end
      if (mode == 1 && n == 6) i_start = 1'b0;
      if (o_done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (!rand_ready) check({tag, "_done_cycle"}, n, tiles + 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_busy_at_done"}, o_busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, o_done, 1'b0);
    check({tag, "_idle_valid"}, o_tile_valid, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    TilePointers c1, c2, c4, c5;
    bit got3;
    i_rstn = 1'b0; i_start = 1'b0; i_tile_ready = 1'b1; i_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_valid", o_tile_valid, 1'b0);
    check("rst_desc", act, '0);
    @(posedge clk); #1 i_rstn = 1'b1;

    // 1: single tile
    c1 = '0;
    c1.psums.x_step = 32'd3; c1.psums.y_step = 32'd5; c1.psums.k_step = 32'd7;
    c1.ifmaps.x_step = 32'd11; c1.ifmaps.y_step = 32'd13; c1.ifmaps.c_step = 32'd17;
    c1.weights.k_step = 32'd19; c1.weights.c_step = 32'd23;
    run_test("t1", c1, 0);

    // 2: 12 tiles back-to-back
    c2 = '0;
    c2.c_lim = 16'd2; c2.x_lim = 16'd1; c2.y_lim = 16'd0; c2.k_lim = 16'd1;
    c2.ifmaps.c_step = 32'd4; c2.ifmaps.x_step = 32'd100; c2.ifmaps.y_step = 32'd7;
    c2.psums.x_step = 32'd3; c2.psums.y_step = 32'd5; c2.psums.k_step = 32'd1000;
    c2.weights.k_step = 32'd50; c2.weights.c_step = 32'd2;
    run_test("t2", c2, 0);

    // 3: same nest under random backpressure
    rand_ready = 1;
    run_test("t3", c2, 0);
    rand_ready = 0;
    @(posedge clk); #1 i_tile_ready = 1'b1;

    // 4: start + cfg change during RUN, nest with y levels
    c4 = c2;
    c4.c_lim = 16'd1; c4.x_lim = 16'd1; c4.y_lim = 16'd2; c4.k_lim = 16'd1;
    run_test("t4", c4, 1);

    // 5: modulo-2^32 wrap of psums
    c5 = '0;
    c5.k_lim = 16'd1; c5.x_lim = 16'd2;
    c5.psums.k_step = 32'hFFFF_FFF0; c5.psums.x_step = 32'h0000_0010;
    c5.ifmaps.x_step = 32'h8000_0000; c5.weights.k_step = 32'd9;
    run_test("t5", c5, 0);

    // 6: reset after 3 tiles, then replay
    n_hs = 0;
    push_nest(c2);
    do_start(c2);
    got3 = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (n_hs >= 3) begin
        got3 = 1;
        break;
      end
    end
    check("t6_three_tiles", got3, 1'b1);
    #1 i_rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_busy", o_busy, 1'b0);
    check("t6_rst_valid", o_tile_valid, 1'b0);
    check("t6_rst_done", o_done, 1'b0);
    exp_q.delete();
    @(posedge clk); #1 i_rstn = 1'b1;
    @(negedge clk);
    check("t6_no_done", o_done, 1'b0);
    run_test("t6", c2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
